// File: rtl/coax_rx_frame_ctrl.sv
// Coax receive frame controller.
// Hunts for the start sequence (a run of 1s then a 0), then frames 12-bit words
// (sync, 10 data bits MSB first, even parity) until a 0 sync bit ends the frame.
// Every frame end or abort also pulses timer_reset_o so the bit timer re-acquires.
module coax_rx_frame_ctrl #(
  parameter int unsigned START_ONES = 5,
  parameter int unsigned MAX_WORDS  = 1024,
  localparam int unsigned WcW       = $clog2(MAX_WORDS + 1)
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           enable_i,
  input  logic           sample_i,
  input  logic           rx_bit_i,
  input  logic           synchronized_i,
  output logic [9:0]     data_o,
  output logic           data_strobe_o,
  output logic           parity_error_o,
  output logic           active_o,
  output logic           frame_done_o,
  output logic           error_o,
  output logic [1:0]     error_code_o,
  output logic [WcW-1:0] word_count_o,
  output logic           timer_reset_o
);

  localparam int unsigned OnesW = $clog2(START_ONES + 1);
  localparam logic [OnesW-1:0] OnesMax = OnesW'(START_ONES);
  localparam logic [WcW-1:0]   WcMax   = WcW'(MAX_WORDS);

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrLoss     = 2'd1;
  localparam logic [1:0] ErrOverflow = 2'd2;
  localparam logic [1:0] ErrEmpty    = 2'd3;

  typedef enum logic [2:0] {StIdle, StHunt, StSync, StData, StParity} state_e;

  state_e           state_q;
  logic [OnesW-1:0] ones_q;
  logic [3:0]       bit_idx_q;
  logic [9:0]       shift_q;
  logic [9:0]       data_q;
  logic             data_strobe_q;
  logic             parity_error_q;
  logic             active_q;
  logic             frame_done_q;
  logic             error_q;
  logic [1:0]       error_code_q;
  logic [WcW-1:0]   word_count_q;
  logic             timer_reset_q;
  logic [1:0]       abort_code;

  // Abort decode: loss of lock wins over any coincident sample.
  always_comb begin
    abort_code = ErrNone;
    if (state_q == StSync || state_q == StData || state_q == StParity) begin
      if (!synchronized_i) begin
        abort_code = ErrLoss;
      end else if (sample_i && state_q == StSync) begin
        // Overflow is checked before the increment, so word_count never wraps.
        if (rx_bit_i && word_count_q == WcMax) begin
          abort_code = ErrOverflow;
        end else if (!rx_bit_i && word_count_q == '0) begin
          abort_code = ErrEmpty;
        end
      end
    end
  end

  // Frame sequencer with registered outputs; strobes last one cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= StIdle;
      ones_q         <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      data_q         <= '0;
      data_strobe_q  <= 1'b0;
      parity_error_q <= 1'b0;
      active_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= ErrNone;
      word_count_q   <= '0;
      timer_reset_q  <= 1'b0;
    end else begin
      data_strobe_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      timer_reset_q <= 1'b0;
      if (abort_code != ErrNone) begin
        error_q       <= 1'b1;
        timer_reset_q <= 1'b1;
        error_code_q  <= abort_code;
        active_q      <= 1'b0;
        state_q       <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (enable_i && synchronized_i) begin
              ones_q  <= '0;
              state_q <= StHunt;
            end
          end
          StHunt: begin
            if (!enable_i || !synchronized_i) begin
              state_q <= StIdle;
            end else if (sample_i) begin
              if (rx_bit_i) begin
                if (ones_q < OnesMax) ones_q <= ones_q + 1'b1;
              end else if (ones_q >= OnesMax) begin
                ones_q       <= '0;
                active_q     <= 1'b1;
                word_count_q <= '0;
                state_q      <= StSync;
              end else begin
                ones_q <= '0;
              end
            end
          end
          StSync: begin
            if (sample_i) begin
              if (rx_bit_i) begin
                bit_idx_q <= '0;
                state_q   <= StData;
              end else begin
                frame_done_q  <= 1'b1;
                timer_reset_q <= 1'b1;
                active_q      <= 1'b0;
                state_q       <= StIdle;
              end
            end
          end
          StData: begin
            if (sample_i) begin
              shift_q <= {shift_q[8:0], rx_bit_i};
              if (bit_idx_q == 4'd9) begin
                state_q <= StParity;
              end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
              end
            end
          end
          StParity: begin
            if (sample_i) begin
              data_q         <= shift_q;
              parity_error_q <= rx_bit_i ^ (^shift_q);
              data_strobe_q  <= 1'b1;
              word_count_q   <= word_count_q + 1'b1;
              state_q        <= StSync;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_o         = data_q;
  assign data_strobe_o  = data_strobe_q;
  assign parity_error_o = parity_error_q;
  assign active_o       = active_q;
  assign frame_done_o   = frame_done_q;
  assign error_o        = error_q;
  assign error_code_o   = error_code_q;
  assign word_count_o   = word_count_q;
  assign timer_reset_o  = timer_reset_q;

endmodule

// File: tb/tb_coax_rx_frame_ctrl.sv
// Bench for coax_rx_frame_ctrl: randomized frames with a scoreboard of expected
// output events (word, frame done, abort) checked by an independent monitor.
module tb_coax_rx_frame_ctrl;

  localparam int MAX_W = 2;
  localparam int WCW   = $clog2(MAX_W + 1);

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           sample;
  logic           rx_bit;
  logic           synchronized;
  logic [9:0]     data;
  logic           data_strobe;
  logic           parity_error;
  logic           active;
  logic           frame_done;
  logic           error;
  logic [1:0]     error_code;
  logic [WCW-1:0] word_count;
  logic           timer_reset;

  coax_rx_frame_ctrl #(
    .START_ONES(5),
    .MAX_WORDS (MAX_W)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .enable_i      (enable),
    .sample_i      (sample),
    .rx_bit_i      (rx_bit),
    .synchronized_i(synchronized),
    .data_o        (data),
    .data_strobe_o (data_strobe),
    .parity_error_o(parity_error),
    .active_o      (active),
    .frame_done_o  (frame_done),
    .error_o       (error),
    .error_code_o  (error_code),
    .word_count_o  (word_count),
    .timer_reset_o (timer_reset)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 = data word, 1 = frame done, 2 = abort
  typedef struct {
    int         kind;
    logic [9:0] data;
    logic       perr;
    logic [1:0] code;
    int         wc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic [1:0] last_code = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [9:0] d, input logic p,
                         input logic [1:0] code, input int wc);
    ev_t e;
    e.kind = kind; e.data = d; e.perr = p; e.code = code; e.wc = wc;
    exp_q.push_back(e);
    if (kind == 2) last_code = code;
  endtask

  // Monitor: any strobe pops the next expected event.
  ev_t me;
  always @(negedge clk) begin
    if (reset_n && (data_strobe || frame_done || error || timer_reset)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: strobe=%0b done=%0b err=%0b trst=%0b expected none",
                 data_strobe, frame_done, error, timer_reset);
      end else begin
        me = exp_q.pop_front();
        check("data_strobe", 32'(data_strobe), 32'(me.kind == 0));
        check("frame_done", 32'(frame_done), 32'(me.kind == 1));
        check("error", 32'(error), 32'(me.kind == 2));
        check("timer_reset", 32'(timer_reset), 32'(me.kind != 0));
        check("word_count", 32'(word_count), 32'(me.wc));
        if (me.kind == 0) begin
          check("data", 32'(data), 32'(me.data));
          check("parity_error", 32'(parity_error), 32'(me.perr));
        end
        if (me.kind == 2) check("error_code", 32'(error_code), 32'(me.code));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit-timer sample after a random idle gap; returns just after the capturing edge.
  task automatic send_bit(input logic b);
    int gap = $urandom_range(1, 3);
    repeat (gap) begin
      sample = 1'b0;
      rx_bit = 1'($urandom);
      tick();
    end
    sample = 1'b1;
    rx_bit = b;
    tick();
    sample = 1'b0;
  endtask

  task automatic start_frame(input int pre);
    enable = 1'b1;
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    check("active_at_start", 32'(active), 32'd1);
    check("wc_cleared", 32'(word_count), 32'd0);
  endtask

  task automatic send_word(input logic [9:0] w, input logic p, input int idx);
    enable = 1'($urandom);
    send_bit(1'b1);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
    push_ev(0, w, 1'(($countones(w) + int'(p)) % 2), 2'd0, idx);
    send_bit(p);
  endtask

  task automatic end_frame(input int nw);
    if (nw == 0) push_ev(2, 10'd0, 1'b0, 2'd3, 0);
    else push_ev(1, 10'd0, 1'b0, 2'd0, nw);
    send_bit(1'b0);
    check("active_after_end", 32'(active), 32'd0);
    enable = 1'b1;
  endtask

  task automatic clean_frame(input int nw);
    start_frame($urandom_range(5, 8));
    for (int i = 0; i < nw; i++) send_word(10'($urandom), 1'($urandom), i + 1);
    end_frame(nw);
  endtask

  task automatic overflow_frame();
    start_frame($urandom_range(5, 8));
    for (int i = 0; i < MAX_W; i++) send_word(10'($urandom), 1'($urandom), i + 1);
    push_ev(2, 10'd0, 1'b0, 2'd2, MAX_W);
    send_bit(1'b1);
    check("active_after_overflow", 32'(active), 32'd0);
    check("wc_after_overflow", 32'(word_count), 32'(MAX_W));
    enable = 1'b1;
  endtask

  // k < 0: drop in SYNC; 0..9: after k data bits; 10: in PARITY.
  task automatic loss_frame(input int nw, input int k, input logic coincide);
    logic [9:0] w = 10'($urandom);
    start_frame($urandom_range(5, 8));
    for (int i = 0; i < nw; i++) send_word(10'($urandom), 1'($urandom), i + 1);
    if (k >= 0) begin
      send_bit(1'b1);
      for (int i = 0; i < k; i++) send_bit(w[9-i]);
    end
    push_ev(2, 10'd0, 1'b0, 2'd1, nw);
    synchronized = 1'b0;
    sample = coincide;
    rx_bit = 1'($urandom);
    tick();
    sample = 1'b0;
    check("active_after_loss", 32'(active), 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    synchronized = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    sample = 1'b0;
    rx_bit = 1'b0;
    synchronized = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {data, data_strobe, parity_error, active, frame_done, error,
                            error_code, 32'(word_count), timer_reset}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b1;
    synchronized = 1'b1;
    tick();
    tick();

    // Basic word, good and bad parity
    start_frame(5);
    send_word(10'h2A5, 1'b1, 1);
    end_frame(1);
    check("wc_after_frame", 32'(word_count), 32'd1);
    start_frame(5);
    send_word(10'h2A5, 1'b0, 1);
    end_frame(1);

    // Short preamble must not start a frame
    repeat (4) send_bit(1'b1);
    send_bit(1'b0);
    check("active_short_preamble", 32'(active), 32'd0);
    clean_frame(1);

    // Loss after the 4th data sample, overflow, empty
    loss_frame(0, 4, 1'b0);
    check("error_code_loss", 32'(error_code), 32'd1);
    overflow_frame();
    start_frame(5);
    end_frame(0);
    check("error_code_held", 32'(error_code), 32'd3);

    // Asynchronous reset mid-DATA, then a clean frame
    start_frame(5);
    send_word(10'h3FF, 1'b0, 1);
    send_bit(1'b1);
    repeat (3) send_bit(1'($urandom));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {data, data_strobe, parity_error, active, frame_done, error,
                                  error_code, 32'(word_count), timer_reset}, 32'd0);
    last_code = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    clean_frame(2);

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 9);
      case (r)
        0: begin start_frame($urandom_range(5, 8)); end_frame(0); end
        1: overflow_frame();
        2: loss_frame($urandom_range(0, MAX_W), $urandom_range(0, 11) - 1, 1'($urandom));
        3: begin
          enable = 1'b1;
          repeat ($urandom_range(0, 4)) send_bit(1'b1);
          send_bit(1'b0);
          check("active_noise", 32'(active), 32'd0);
          clean_frame($urandom_range(1, MAX_W));
        end
        default: clean_frame($urandom_range(1, MAX_W));
      endcase
    end

    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("error_code_final", 32'(error_code), 32'(last_code));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
